// File: rtl/mult_div_unit_pkg.sv
// Shared E/D-stage header: multiply/divide op codes, default latencies,
// and the branch op definitions used by the D-stage condition logic.
package mult_div_unit_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6
  } br_op_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_result_t;

  function automatic logic md_is_arith(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_mul(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// E-stage multi-cycle multiply/divide unit owning HI/LO. The result is computed
// at issue into shadow registers and committed when the latency counter expires.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [3:0]  md_op,
  input  logic [31:0] md_srcA,
  input  logic [31:0] md_srcB,
  output logic        md_busy,
  output logic [31:0] md_hi,
  output logic [31:0] md_lo,
  output logic [31:0] md_out
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_BUSY = 1'b1;

  localparam logic [CNT_W-1:0] L_MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] L_DIV_CNT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] L_ONE      = CNT_W'(1);

  logic             r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_shadow_hi;
  logic [31:0]      r_shadow_lo;

  logic             w_accept;
  md_result_t       w_result;

  // Divide by zero keeps the current HI/LO so the commit is a no-op write.
  function automatic md_result_t calc_result(input logic [3:0]  op,
                                             input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [31:0] cur_hi,
                                             input logic [31:0] cur_lo);
    md_result_t         res;
    logic signed [63:0] sprod;
    logic [63:0]        uprod;
    logic [31:0]        b_nz;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    res.hi = cur_hi;
    res.lo = cur_lo;
    b_nz   = (b == 32'd0) ? 32'd1 : b;
    sprod  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    uprod  = {32'd0, a} * {32'd0, b};
    if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
      sq = 32'sh8000_0000;
      sr = 32'sd0;
    end else begin
      sq = $signed(a) / $signed(b_nz);
      sr = $signed(a) % $signed(b_nz);
    end
    case (op)
      MD_MULT:  begin res.hi = sprod[63:32]; res.lo = sprod[31:0]; end
      MD_MULTU: begin res.hi = uprod[63:32]; res.lo = uprod[31:0]; end
      MD_DIV: begin
        if (b != 32'd0) begin
          res.hi = sr;
          res.lo = sq;
        end
      end
      MD_DIVU: begin
        if (b != 32'd0) begin
          res.hi = a % b_nz;
          res.lo = a / b_nz;
        end
      end
      default: ;
    endcase
    return res;
  endfunction

  assign w_accept = md_start && md_is_arith(md_op) && (r_state == S_IDLE);
  assign w_result = calc_result(md_op, md_srcA, md_srcB, r_hi, r_lo);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_shadow_hi <= '0;
      r_shadow_lo <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shadow_hi <= w_result.hi;
            r_shadow_lo <= w_result.lo;
            r_cnt       <= md_is_mul(md_op) ? L_MULT_CNT : L_DIV_CNT;
            r_state     <= S_BUSY;
          end else if (md_op == MD_MTHI) begin
            r_hi <= md_srcA;
          end else if (md_op == MD_MTLO) begin
            r_lo <= md_srcA;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - L_ONE;
          if (r_cnt == L_ONE) begin
            r_hi    <= r_shadow_hi;
            r_lo    <= r_shadow_lo;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign md_busy = (r_state == S_BUSY);
  assign md_hi   = r_hi;
  assign md_lo   = r_lo;
  assign md_out  = (md_op == MD_MFHI) ? r_hi :
                   (md_op == MD_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, arithmetic corner cases,
// MTHI/MTLO path, ignored starts and asynchronous reset abort.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        md_start;
  logic [3:0]  md_op;
  logic [31:0] md_srcA;
  logic [31:0] md_srcB;
  logic        md_busy;
  logic [31:0] md_hi;
  logic [31:0] md_lo;
  logic [31:0] md_out;

  int n_checks = 0;
  int n_errors = 0;

  mult_div_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10),
    .CNT_W      (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .md_start(md_start),
    .md_op   (md_op),
    .md_srcA (md_srcA),
    .md_srcB (md_srcB),
    .md_busy (md_busy),
    .md_hi   (md_hi),
    .md_lo   (md_lo),
    .md_out  (md_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Called at a negedge; drives a one-cycle start pulse and returns at the next negedge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    md_start = 1'b1;
    md_op    = op;
    md_srcA  = a;
    md_srcB  = b;
    @(negedge clk);
    md_start = 1'b0;
    md_op    = MD_NONE;
  endtask

  task automatic move_to(input logic [3:0] op, input logic [31:0] a);
    md_op   = op;
    md_srcA = a;
    @(negedge clk);
    md_op   = MD_NONE;
  endtask

  // Counts busy cycles observed at negedges, bounded so a stuck busy still ends.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (md_busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cnt;
    reset    = 1'b1;
    md_start = 1'b0;
    md_op    = MD_NONE;
    md_srcA  = '0;
    md_srcB  = '0;
    #2 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, md_busy}, 32'd0);
    check("rst_hi", md_hi, 32'd0);
    check("rst_lo", md_lo, 32'd0);
    check("rst_out", md_out, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // MULT -2 x 3 with prior LO visible through MFLO while busy
    move_to(MD_MTLO, 32'h1234_5678);
    check("mtlo", md_lo, 32'h1234_5678);
    issue(MD_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
    md_op = MD_MFLO;
    #1 check("mflo_busy", md_out, 32'h1234_5678);
    check("mult_busy_hi", md_hi, 32'd0);
    md_op = MD_NONE;
    wait_idle(cnt);
    check("mult_cycles", cnt, 32'd5);
    check("mult_hi", md_hi, 32'hFFFF_FFFF);
    check("mult_lo", md_lo, 32'hFFFF_FFFA);
    md_op = MD_MFHI;
    #1 check("mfhi_out", md_out, 32'hFFFF_FFFF);
    md_op = MD_NONE;
    #1 check("none_out", md_out, 32'd0);

    // MULTU issued in the first idle cycle after busy falls
    @(negedge clk);
    issue(MD_MULT, 32'd1, 32'd1);
    wait_idle(cnt);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("b2b_busy", {31'd0, md_busy}, 32'd1);
    wait_idle(cnt);
    check("multu_cycles", cnt, 32'd5);
    check("multu_hi", md_hi, 32'hFFFF_FFFE);
    check("multu_lo", md_lo, 32'h0000_0001);

    // DIV -7 / 2
    issue(MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_idle(cnt);
    check("div_cycles", cnt, 32'd10);
    check("div_hi", md_hi, 32'hFFFF_FFFF);
    check("div_lo", md_lo, 32'hFFFF_FFFD);

    // DIVU by zero leaves preloaded HI/LO untouched
    move_to(MD_MTHI, 32'h0000_0011);
    move_to(MD_MTLO, 32'h0000_0022);
    issue(MD_DIVU, 32'd7, 32'd0);
    wait_idle(cnt);
    check("div0_cycles", cnt, 32'd10);
    check("div0_hi", md_hi, 32'h0000_0011);
    check("div0_lo", md_lo, 32'h0000_0022);

    // DIV overflow with an ignored MULT start mid-busy
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    cnt = 0;
    while (md_busy && cnt < 40) begin
      cnt++;
      if (cnt == 3) begin
        md_start = 1'b1; md_op = MD_MULT; md_srcA = 32'd2; md_srcB = 32'd2;
      end else begin
        md_start = 1'b0; md_op = MD_NONE;
      end
      @(negedge clk);
    end
    md_start = 1'b0;
    md_op    = MD_NONE;
    check("ovf_cycles", cnt, 32'd10);
    check("ovf_hi", md_hi, 32'd0);
    check("ovf_lo", md_lo, 32'h8000_0000);
    @(negedge clk);
    check("ovf_no_restart", {31'd0, md_busy}, 32'd0);

    // MTHI in idle, MTLO dropped while busy
    move_to(MD_MTHI, 32'hDEAD_BEEF);
    check("mthi", md_hi, 32'hDEAD_BEEF);
    issue(MD_MULT, 32'd5, 32'd6);
    move_to(MD_MTLO, 32'h0000_CAFE);
    check("mtlo_busy_drop", md_lo, 32'h8000_0000);
    wait_idle(cnt);
    check("m56_lo", md_lo, 32'd30);
    check("m56_hi", md_hi, 32'd0);

    // start with a non-arith op code is ignored
    issue(MD_MFHI, 32'd9, 32'd9);
    check("start_mfhi_busy", {31'd0, md_busy}, 32'd0);

    // asynchronous reset at busy cycle 3 aborts the op
    move_to(MD_MTHI, 32'h0000_00AA);
    issue(MD_MULT, 32'd7, 32'd7);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", {31'd0, md_busy}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, md_busy}, 32'd0);
    check("abort_hi", md_hi, 32'd0);
    check("abort_lo", md_lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    issue(MD_MULT, 32'd3, 32'd4);
    wait_idle(cnt);
    check("post_rst_cycles", cnt, 32'd5);
    check("post_rst_lo", md_lo, 32'd12);
    check("post_rst_hi", md_hi, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
